// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with PC register and IF/ID pipeline register.
//
// Holds the fetch PC, selects the next PC, and registers the fetched instruction
// for decode.
//
// The next PC is chosen from these sources:
//   - sequential (PC + 4)
//   - a taken branch from decode
//   - a jump target built from the decode-stage instruction
//
// The IF/ID register can be stalled or flushed. A flush inserts a bubble, which
// is a nop with ValidD = 0.
//
// Parameters:
//   WIDTH     width of the PC, instruction and address paths (>= 32)
//   RESET_PC  PC loaded while RST is high
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active high; overrides every other control input
//   InstrF     instruction word read combinationally from imem[PCF]
//   StallF     hold the PC register
//   StallD     hold the IF/ID register
//   FlushD     clear the IF/ID register to a bubble; wins over StallD
//   PCSrcD     next-PC select: bit1 = jump (has priority), bit0 = taken branch
//   PCBranchD  branch target from decode
//   PCF        current fetch address
//   InstrD     registered instruction for decode
//   PCPlus4D   registered PCF + 4 for decode
//   ValidD     InstrD holds a real fetched instruction
//
// Optional feature (macro FETCH_PERF_CNT_EN), which adds two free-running 32-bit
// counters that wrap and are cleared by RST:
//   FetchCount     edges on which IF/ID loaded a valid instruction
//   RedirectCount  edges on which the PC loaded a branch or jump target
module fetch_stage #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(32'h0000_0000)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] InstrF,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic [1:0]       PCSrcD,
  input  logic [WIDTH-1:0] PCBranchD,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      FetchCount,
  output logic [31:0]      RedirectCount
`endif
);

  // Sequential successor of a PC; wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(4);
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pc_plus4_p0;
  logic [WIDTH-1:0] pc_jump_p1;
  logic [WIDTH-1:0] pc_next_p0;
  logic [WIDTH-1:0] instr_p1;
  logic [WIDTH-1:0] pc_plus4_p1;
  logic             vld_p1;

  assign pc_plus4_p0 = pc_inc(pc_p0);

  // The jump target comes from the IF/ID outputs, because the jump is resolved in decode.
  assign pc_jump_p1  = {pc_plus4_p1[WIDTH-1:28], instr_p1[25:0], 2'b00};

  always_comb begin
    pc_next_p0 = pc_plus4_p0;
    if (PCSrcD[1])      pc_next_p0 = pc_jump_p1;
    else if (PCSrcD[0]) pc_next_p0 = PCBranchD;
  end

  // Stage 0: PC register
  always_ff @(posedge CLK) begin
    if (RST)          pc_p0 <= RESET_PC;
    else if (!StallF) pc_p0 <= pc_next_p0;
  end

  // Stage 1: IF/ID register (a flush overrides a stall)
  always_ff @(posedge CLK) begin
    if (RST || FlushD) begin
      instr_p1    <= '0;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (!StallD) begin
      instr_p1    <= InstrF;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!StallD && !FlushD)          fetch_cnt    <= fetch_cnt + 32'd1;
      if (!StallF && (PCSrcD != 2'b00)) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign FetchCount    = fetch_cnt;
  assign RedirectCount = redirect_cnt;
`endif

  assign PCF      = pc_p0;
  assign InstrD   = instr_p1;
  assign PCPlus4D = pc_plus4_p1;
  assign ValidD   = vld_p1;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WIDTH, default 32: width of PC, instruction and address paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset is synchronous and active-high.
REQ-005 InstrF  input  WIDTH: instruction word from instruction memory; combinational read at address PCF.
REQ-006 StallF  input  1: hold PC register.
REQ-007 StallD  input  1: hold IF/ID register.
REQ-008 FlushD  input  1: clear IF/ID register (bubble).
REQ-009 PCSrcD  input  2: next-PC select from decode; bit1 = jump, bit0 = taken branch.
REQ-010 PCBranchD  input  WIDTH: branch target from decode.
REQ-011 PCF  output  WIDTH: current fetch address; drives instruction memory address.
REQ-012 InstrD  output  WIDTH: registered instruction for decode.
REQ-013 PCPlus4D  output  WIDTH: registered PCF+4 for decode.
REQ-014 ValidD  output  1: InstrD holds a real fetched instruction (0 = bubble).

Function
REQ-015 PCPlus4F SHALL equal PCF + 4, modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 PCJumpD SHALL equal {PCPlus4D[31:28], InstrD[25:0], 2'b00}, computed from the IF/ID register outputs.
REQ-017 Next PC: PCSrcD=00 -> PCPlus4F; 01 -> PCBranchD; 10 -> PCJumpD; 11 -> PCJumpD (jump has priority).
REQ-018 PC register SHALL load next PC each edge unless StallF=1, in which case it holds, including when PCSrcD != 00.
REQ-019 IF/ID register SHALL load InstrF, PCPlus4F and ValidD=1 each edge when StallD=0 and FlushD=0.
REQ-020 StallD=1 with FlushD=0: InstrD, PCPlus4D and ValidD hold.
REQ-021 FlushD=1: InstrD=0 (nop), PCPlus4D=0 and ValidD=0 on the next edge, regardless of StallD.
REQ-022 Latency: an instruction at PCF appears on InstrD exactly one cycle later when not stalled or flushed.
REQ-023 Redirect: a branch or jump resolved in decode takes effect on PCF at the next edge; the decode stage asserts FlushD in the same cycle to discard the wrong-path instruction.

Reset
REQ-024 RST=1 at an edge: PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0; RST overrides StallF, StallD, FlushD and PCSrcD.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the pending state with no residual effect after RST deasserts.
REQ-026 The first edge after RST deasserts fetches from RESET_PC, so InstrD receives mem[RESET_PC].

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN defined: add outputs FetchCount (32) and RedirectCount (32), both reset to 0.
REQ-028 FetchCount increments on each edge where the IF/ID register loads a valid instruction; RedirectCount increments on each edge where the PC loads with PCSrcD != 00 and StallF=0.
REQ-029 Both counters wrap from 32'hFFFF_FFFF to 0.
REQ-030 Macro FETCH_PERF_CNT_EN undefined: no counter ports or logic; all other behaviour identical.

Verification
REQ-031 Sequential fetch: RST 1 cycle, then 4 cycles with no stall or flush and mem[0..12] = A,B,C,D -> PCF 0,4,8,12,16; InstrD A,B,C,D one cycle later; ValidD=1.
REQ-032 Stall: StallF=StallD=1 for 2 cycles with PCF=8 -> PCF stays 8 and InstrD stays at the word from address 4; resumes at 8 -> 12 afterwards.
REQ-033 Branch: PCSrcD=01, PCBranchD=0x40, FlushD=1 -> next PCF=0x40, InstrD=0, ValidD=0; the following cycle InstrD=mem[0x40].
REQ-034 Jump: InstrD=0x08000010, PCPlus4D=0x00000008, PCSrcD=10 -> next PCF=0x00000040; PCSrcD=11 gives the same result.
REQ-035 Conflicts: FlushD=1 and StallD=1 together -> bubble inserted; StallF=1 and PCSrcD=01 together -> PCF unchanged.
REQ-036 Boundaries: RST during a stall -> PCF=RESET_PC next edge; PCF=0xFFFFFFFC -> PCPlus4 wraps to 0; with FETCH_PERF_CNT_EN, counter preset near 32'hFFFF_FFFF wraps to 0 and clears on RST.
